// File: rtl/uart_tx_bus_responder.sv
// ============================================================================
// uart_tx_bus_responder
// ----------------------------------------------------------------------------
// Memory-mapped UART transmitter that sits on the MEM-stage data bus. The CPU
// stores bytes into a TX FIFO. A baud-timed FSM then sends each byte as an
// 8N1 frame on tx (8O1/8E1 when parity is enabled).
//
// Build option:
//   UART_TX_PARITY_EN  - when defined, a PARITY bit follows the data bits.
//                        The bit is even parity, or odd parity when DIV[16]=1.
//                        The frame is then 11 bits long. When undefined,
//                        DIV[16] reads 0 and ignores writes.
//
// Parameters:
//   FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//   DIV_RESET   reset value of DIV; one bit lasts DIV+1 clk cycles
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   busCs      chip select
//   busWe      write strobe, qualified by busCs
//   busAddr    byte offset; [3:2] selects the register
//   busWData   write data
//   busRData   combinational read data (0 when busCs=0)
//   tx         serial output, idle high
//   irq_empty  high while the FIFO is empty and the transmitter is idle
//
// Register map:
//   0x0 DATA   W    [7:0] pushed to the FIFO; reads 0
//   0x4 STATUS R/W1C [0] full [1] empty [2] busy [3] overflow (W1C)
//                    [7:4] FIFO count, saturating at 15
//   0x8 DIV    R/W  [15:0] baud divisor ([16] odd parity with parity enabled)
//   0xC        reads 0, writes ignored
// ============================================================================
module uart_tx_bus_responder #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busCs,
    input  logic        busWe,
    input  logic [3:0]  busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        tx,
    output logic        irq_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        stateReg, stateNext;
    logic [15:0]   tickReg, tickNext;
    logic [2:0]    bitReg, bitNext;
    logic [7:0]    shifterReg, shifterNext;
    logic [15:0]   divQReg, divQNext;
    logic          parityReg, parityNext;
    logic [15:0]   divReg, divNext;
    logic          overflowReg, overflowNext;
    logic [AW:0]   wrPtrReg, rdPtrReg;
    logic [7:0]    fifoMem [FIFO_DEPTH];

    logic          parOdd;
`ifdef UART_TX_PARITY_EN
    logic          parOddReg, parOddNext;
    assign parOdd = parOddReg;
`else
    assign parOdd = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] regSel;
    logic       wrStrobe;
    logic       pushReq;
    logic       pushAccept;
    logic       pop;

    assign regSel   = busAddr[3:2];
    assign wrStrobe = busCs && busWe;
    assign pushReq  = wrStrobe && (regSel == 2'd0);

    // ------------------------------------------------------------------
    // FIFO status (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [AW:0]  fifoCount;
    logic         fifoEmpty;
    logic         fifoFull;
    logic [7:0]   fifoHead;
    logic [31:0]  countWide;
    logic [3:0]   countSat;

    assign fifoCount = wrPtrReg - rdPtrReg;
    assign fifoEmpty = (wrPtrReg == rdPtrReg);
    assign fifoFull  = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                       (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
    assign fifoHead  = fifoMem[rdPtrReg[AW-1:0]];
    assign countWide = 32'(fifoCount);
    assign countSat  = (countWide > 32'd15) ? 4'hF : countWide[3:0];

    // A pop in the same cycle frees the slot that the push reuses.
    assign pushAccept = pushReq && (!fifoFull || pop);

    // ------------------------------------------------------------------
    // FIFO storage: no reset, write-only port here. The head is captured
    // into the shifter on pop, which acts as the registered read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            fifoMem[wrPtrReg[AW-1:0]] <= busWData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (pushAccept) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        overflowNext = overflowReg;
        divNext      = divReg;
        if (wrStrobe && (regSel == 2'd1) && busWData[3]) begin
            overflowNext = 1'b0;
        end
        // Placed after the clear so a dropped push wins over a W1C.
        if (pushReq && !pushAccept) begin
            overflowNext = 1'b1;
        end
        if (wrStrobe && (regSel == 2'd2)) begin
            divNext = busWData[15:0];
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parOddNext = parOddReg;
        if (wrStrobe && (regSel == 2'd2)) begin
            parOddNext = busWData[16];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Transmit FSM: next state
    // ------------------------------------------------------------------
    logic tickDone;
    assign tickDone = (tickReg == divQReg);

    always_comb begin
        stateNext   = stateReg;
        tickNext    = tickReg;
        bitNext     = bitReg;
        shifterNext = shifterReg;
        divQNext    = divQReg;
        parityNext  = parityReg;
        pop         = 1'b0;

        case (stateReg)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    pop         = 1'b1;
                    shifterNext = fifoHead;
                    divQNext    = divReg;
                    parityNext  = (^fifoHead) ^ parOdd;
                    tickNext    = '0;
                    bitNext     = '0;
                    stateNext   = ST_START;
                end
            end

            ST_START: begin
                if (tickDone) begin
                    tickNext  = '0;
                    bitNext   = '0;
                    stateNext = ST_DATA;
                end else begin
                    tickNext = tickReg + 16'd1;
                end
            end

            ST_DATA: begin
                if (tickDone) begin
                    tickNext    = '0;
                    shifterNext = {1'b0, shifterReg[7:1]};
                    if (bitReg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = ST_PARITY;
`else
                        stateNext = ST_STOP;
`endif
                    end else begin
                        bitNext = bitReg + 3'd1;
                    end
                end else begin
                    tickNext = tickReg + 16'd1;
                end
            end

            ST_PARITY: begin
                if (tickDone) begin
                    tickNext  = '0;
                    stateNext = ST_STOP;
                end else begin
                    tickNext = tickReg + 16'd1;
                end
            end

            ST_STOP: begin
                if (tickDone) begin
                    tickNext = '0;
                    if (!fifoEmpty) begin
                        // Back-to-back: next START begins with no idle gap.
                        pop         = 1'b1;
                        shifterNext = fifoHead;
                        divQNext    = divReg;
                        parityNext  = (^fifoHead) ^ parOdd;
                        bitNext     = '0;
                        stateNext   = ST_START;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end else begin
                    tickNext = tickReg + 16'd1;
                end
            end

            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= ST_IDLE;
            tickReg     <= '0;
            bitReg      <= '0;
            shifterReg  <= '0;
            divQReg     <= '0;
            parityReg   <= 1'b0;
            overflowReg <= 1'b0;
            divReg      <= DIV_RESET;
        end else begin
            stateReg    <= stateNext;
            tickReg     <= tickNext;
            bitReg      <= bitNext;
            shifterReg  <= shifterNext;
            divQReg     <= divQNext;
            parityReg   <= parityNext;
            overflowReg <= overflowNext;
            divReg      <= divNext;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parOddReg <= 1'b0;
        end else begin
            parOddReg <= parOddNext;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic        busy;
    logic [31:0] statusWord;
    logic [31:0] divWord;

    assign busy       = (stateReg != ST_IDLE);
    assign statusWord = {24'd0, countSat, overflowReg, busy, fifoEmpty, fifoFull};
`ifdef UART_TX_PARITY_EN
    assign divWord    = {15'd0, parOddReg, divReg};
`else
    assign divWord    = {16'd0, divReg};
`endif

    always_comb begin
        busRData = '0;
        if (busCs) begin
            case (regSel)
                2'd1:    busRData = statusWord;
                2'd2:    busRData = divWord;
                default: busRData = '0;
            endcase
        end
    end

    always_comb begin
        case (stateReg)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shifterReg[0];
            ST_PARITY: tx = parityReg;
            default:   tx = 1'b1;
        endcase
    end

    assign irq_empty = fifoEmpty && (stateReg == ST_IDLE);

    // Bus bits with no function in this register map.
    logic unusedBits;
`ifdef UART_TX_PARITY_EN
    assign unusedBits = ^{busWData[31:17], busAddr[1:0]};
`else
    assign unusedBits = ^{busWData[31:16], busAddr[1:0]};
`endif

endmodule

// File: tb/tb_uart_tx_bus_responder.sv
// ============================================================================
// tb_uart_tx_bus_responder
// ----------------------------------------------------------------------------
// Scoreboard bench for uart_tx_bus_responder. Each accepted byte pushes an
// expected frame into a queue. Each frame carries its data, its divisor and
// its parity sense. A monitor detects every start bit on tx and pops the head
// of the queue. It then rebuilds the ideal waveform from the frame format and
// compares tx against it on every cycle of the frame.
// ============================================================================
module tb_uart_tx_bus_responder;

    localparam int FIFO_DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic        clk;
    logic        reset;
    logic        busCs;
    logic        busWe;
    logic [3:0]  busAddr;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        tx;
    logic        irq_empty;

    uart_tx_bus_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_RESET  (16'd867)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .busCs     (busCs),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWData  (busWData),
        .busRData  (busRData),
        .tx        (tx),
        .irq_empty (irq_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         odd;
    } exp_t;

    exp_t expQ[$];
    int   startQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resetCnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) resetCnt <= resetCnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic expectFrame(input logic [7:0] d, input int div, input bit odd);
        exp_t e;
        e.data = d;
        e.div  = div;
        e.odd  = odd;
        expQ.push_back(e);
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        busCs    = 1'b1;
        busWe    = 1'b1;
        busAddr  = a;
        busWData = d;
    endtask

    task automatic busIdle();
        @(negedge clk);
        busCs    = 1'b0;
        busWe    = 1'b0;
        busAddr  = 4'h0;
        busWData = 32'h0;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        busCs   = 1'b1;
        busWe   = 1'b0;
        busAddr = a;
        #1 d = busRData;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(irq_empty === 1'b1 && expQ.size() == 0) && n < budget);
        if (!(irq_empty === 1'b1 && expQ.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: irq_empty=%b pending_frames=%0d, required idle with 0 pending",
                     irq_empty, expQ.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one comparison per completed frame
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        logic frameBits [FL];
        int   bitLen;
        int   bad;
        int   firstBad;
        int   rc;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                startQ.push_back(cyc);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                end else begin
                    e = expQ.pop_front();
                    bitLen = e.div + 1;
                    frameBits[0] = 1'b0;
                    for (int b = 0; b < 8; b++) frameBits[b + 1] = e.data[b];
`ifdef UART_TX_PARITY_EN
                    frameBits[9]  = (^e.data) ^ e.odd;
`endif
                    frameBits[FL - 1] = 1'b1;
                    rc = resetCnt;
                    bad = 0;
                    firstBad = -1;
                    aborted = 1'b0;
                    for (int k = 0; k < FL * bitLen; k++) begin
                        if (k > 0) @(negedge clk);
                        if (resetCnt != rc) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== frameBits[k / bitLen]) begin
                            bad++;
                            if (firstBad < 0) firstBad = k;
                        end
                    end
                    if (!aborted) begin
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL frame_%02h: %0d wrong tx samples (first at cycle %0d of frame, div %0d), required 0",
                                     e.data, bad, firstBad, e.div);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] r;
        logic [31:0] wd;
        logic [31:0] expDiv;
        logic [7:0]  b;
        int          d;
        int          n;
        int          gap;
        bit          odd;

        reset    = 1'b1;
        busCs    = 1'b0;
        busWe    = 1'b0;
        busAddr  = 4'h0;
        busWData = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq_empty", {31'd0, irq_empty}, 32'd1);
        busRead(4'h4, r); chk("reset_status", r, 32'h02);
        busRead(4'h8, r); chk("reset_div", r, 32'd867);
        busRead(4'h0, r); chk("read_data_reg", r, 32'h0);
        busRead(4'hC, r); chk("read_reg_c", r, 32'h0);
        @(negedge clk);
        busCs = 1'b0; busAddr = 4'h4;
        #1 chk("read_no_cs", busRData, 32'h0);

        // DIV=3, single byte 0x55, with first-bit latency
        busWrite(4'h8, 32'd3);
        busWrite(4'h0, 32'h55);
        expectFrame(8'h55, 3, 1'b0);
        busIdle();
        chk("latency_tx_before_pop", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("latency_tx_start", {31'd0, tx}, 32'd0);
        repeat (10) @(negedge clk);
        busRead(4'h4, r);
        chk("busy_midframe", {31'd0, r[2]}, 32'd1);
        chk("irq_empty_midframe", {31'd0, irq_empty}, 32'd0);
        waitIdle(5000);
        busRead(4'h4, r); chk("status_after_frame", r, 32'h02);
        chk("irq_empty_after_frame", {31'd0, irq_empty}, 32'd1);

        // DIV=0, two bytes back-to-back
        startQ.delete();
        busWrite(4'h8, 32'd0);
        busWrite(4'h0, 32'hA0); expectFrame(8'hA0, 0, 1'b0);
        busWrite(4'h0, 32'h0F); expectFrame(8'h0F, 0, 1'b0);
        busIdle();
        waitIdle(5000);
        chk("b2b_frame_count", startQ.size(), 32'd2);
        if (startQ.size() == 2)
            chk("b2b_no_gap", startQ[1] - startQ[0], FL);

        // DIV=7, burst of 10: one byte goes straight out, DEPTH more fill the FIFO
        busWrite(4'h8, 32'd7);
        for (int i = 0; i < 10; i++) begin
            b = 8'(8'h30 + i * 7);
            busWrite(4'h0, {24'd0, b});
            if (i < FIFO_DEPTH + 1) expectFrame(b, 7, 1'b0);
        end
        busIdle();
        busRead(4'h4, r);
        chk("overflow_status_full", r, 32'h8D);
        busWrite(4'h4, 32'h8);
        busIdle();
        busRead(4'h4, r);
        chk("overflow_w1c", r, 32'h85);
        waitIdle(5000);

        // DIV change mid-frame applies to the next frame only
        startQ.delete();
        busWrite(4'h8, 32'd5);
        busWrite(4'h0, 32'h5A); expectFrame(8'h5A, 5, 1'b0);
        busWrite(4'h0, 32'hC3); expectFrame(8'hC3, 1, 1'b0);
        busIdle();
        repeat (20) @(negedge clk);
        busWrite(4'h8, 32'd1);
        busIdle();
        waitIdle(5000);
        chk("middiv_frame_count", startQ.size(), 32'd2);
        if (startQ.size() == 2)
            chk("middiv_first_length", startQ[1] - startQ[0], FL * 6);

        // Reset during DATA bit 3
        busWrite(4'h8, 32'd3);
        busWrite(4'h0, 32'h11); expectFrame(8'h11, 3, 1'b0);
        busWrite(4'h0, 32'h22); expectFrame(8'h22, 3, 1'b0);
        busIdle();
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_irq_empty", {31'd0, irq_empty}, 32'd1);
        busRead(4'h4, r); chk("midreset_status", r, 32'h02);
        busRead(4'h8, r); chk("midreset_div", r, 32'd867);
        busWrite(4'h8, 32'd3);
        busWrite(4'h0, 32'h3C); expectFrame(8'h3C, 3, 1'b0);
        busIdle();
        waitIdle(5000);
        busWrite(4'h8, 32'h0001_0003);
        busRead(4'h8, r);
`ifdef UART_TX_PARITY_EN
        chk("div_odd_readback", r, 32'h0001_0003);
`else
        chk("div_bit16_ignored", r, 32'h0000_0003);
`endif
        busWrite(4'h0, 32'h3C); expectFrame(8'h3C, 3, 1'b1);
        busIdle();
        waitIdle(5000);

        // Randomized bursts; at most DEPTH+1 bytes so none can be dropped
        for (int it = 0; it < 16; it++) begin
            d   = $urandom_range(0, 6);
            odd = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, FIFO_DEPTH + 1);
            wd  = ($urandom() & 32'hFFFE_0000) | {15'd0, odd, 16'(d)};
`ifdef UART_TX_PARITY_EN
            expDiv = {15'd0, odd, 16'(d)};
`else
            expDiv = {16'd0, 16'(d)};
`endif
            busWrite(4'h8, wd);
            busRead(4'h8, r);
            chk("rand_div_readback", r, expDiv);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom());
                busWrite(4'h0, {24'($urandom()), b});
                expectFrame(b, d, odd);
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) busIdle();
            end
            busIdle();
            waitIdle(5000);
        end

        chk("scoreboard_drained", expQ.size(), 32'd0);
        busRead(4'h4, r);
        chk("final_status", r, 32'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
